// File: rtl/sram_ctrl_arb_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_arb_if
// Requester-side handshake bundle for one port of sram_ctrl_arb.
//   req   : access request, held by the master until ack
//   we    : 1 = write, 0 = read
//   addr  : SRAM word address
//   wdata : write data
//   ack   : one-cycle completion pulse (driven by the controller)
//   rdata : read data, valid with ack and held until the next read completes
// Modports: master (on-chip requester), slave (controller side).
// ---------------------------------------------------------------------------
interface sram_ctrl_arb_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );
endinterface

// File: rtl/sram_ctrl_arb.sv
// ---------------------------------------------------------------------------
// sram_ctrl_arb
// Two-requester controller for an asynchronous 8K x 8 SRAM with a shared
// bidirectional data bus. Arbitrates port A / port B, then runs a
// SETUP -> PULSE -> HOLD strobe sequence with programmable cycle counts and
// returns a one-cycle ack (plus read data) to the granted requester.
//
// Ports:
//   clk, rst_n      : clock (rising edge) and asynchronous active-low reset
//   a, b            : requester ports (sram_ctrl_arb_if.slave)
//   sram_cs1_n      : chip select, active low
//   sram_cs2        : chip select, active high
//   sram_we_n       : write enable, active low
//   sram_oe_n       : output enable, active low
//   sram_a          : SRAM address
//   sram_io         : SRAM data bus, driven only during writes
//
// Build option:
//   SRAM_CTRL_FIXED_PRIO_EN defined   -> port A always wins a tie, no pointer
//   SRAM_CTRL_FIXED_PRIO_EN undefined -> round-robin between A and B
// ---------------------------------------------------------------------------
module sram_ctrl_arb #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  sram_ctrl_arb_if.slave    a,
  sram_ctrl_arb_if.slave    b,
  output logic              sram_cs1_n,
  output logic              sram_cs2,
  output logic              sram_we_n,
  output logic              sram_oe_n,
  output logic [ADDR_W-1:0] sram_a,
  inout  wire  [DATA_W-1:0] sram_io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PULSE_LD = 4'(PULSE_CYC - 1);
  localparam logic [3:0] HOLD_LD  = 4'(HOLD_CYC - 1);

  state_t              state_reg, state_next;
  logic [3:0]          cnt_reg, cnt_next;

  // Access context latched at grant time; requester inputs are ignored after.
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic                port_b_reg, port_b_next;
  logic [DATA_W-1:0]   rd_cap_reg, rd_cap_next;

  logic                a_ack_next, b_ack_next;
  logic [DATA_W-1:0]   a_rdata_next, b_rdata_next;

  // Registered pin images.
  logic                cs1_n_next, cs2_next, we_n_next, oe_n_next;
  logic [ADDR_W-1:0]   sram_a_next;
  logic                io_oe_reg, io_oe_next;
  logic [DATA_W-1:0]   io_data_reg, io_data_next;

  logic                a_elig, b_elig, grant_any, grant_b, cs_act;

`ifndef SRAM_CTRL_FIXED_PRIO_EN
  // 1 = port B has priority on the next tie (port A was granted last).
  logic                prio_b_reg, prio_b_next;
`endif

  assign sram_io = io_oe_reg ? io_data_reg : {DATA_W{1'bz}};

  // A port whose ack is high is finishing right now; excluding it stops a
  // still-held req from being granted a second time in the ack cycle.
  assign a_elig    = a.req && !a.ack;
  assign b_elig    = b.req && !b.ack;
  assign grant_any = a_elig || b_elig;

`ifdef SRAM_CTRL_FIXED_PRIO_EN
  assign grant_b = b_elig && !a_elig;
`else
  assign grant_b = b_elig && (!a_elig || prio_b_reg);
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      we_reg      <= 1'b0;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      port_b_reg  <= 1'b0;
      rd_cap_reg  <= '0;
      a.ack       <= 1'b0;
      b.ack       <= 1'b0;
      a.rdata     <= '0;
      b.rdata     <= '0;
      sram_cs1_n  <= 1'b1;
      sram_cs2    <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_a      <= '0;
      io_oe_reg   <= 1'b0;
      io_data_reg <= '0;
`ifndef SRAM_CTRL_FIXED_PRIO_EN
      prio_b_reg  <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      we_reg      <= we_next;
      addr_reg    <= addr_next;
      wdata_reg   <= wdata_next;
      port_b_reg  <= port_b_next;
      rd_cap_reg  <= rd_cap_next;
      a.ack       <= a_ack_next;
      b.ack       <= b_ack_next;
      a.rdata     <= a_rdata_next;
      b.rdata     <= b_rdata_next;
      sram_cs1_n  <= cs1_n_next;
      sram_cs2    <= cs2_next;
      sram_we_n   <= we_n_next;
      sram_oe_n   <= oe_n_next;
      sram_a      <= sram_a_next;
      io_oe_reg   <= io_oe_next;
      io_data_reg <= io_data_next;
`ifndef SRAM_CTRL_FIXED_PRIO_EN
      prio_b_reg  <= prio_b_next;
`endif
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    we_next      = we_reg;
    addr_next    = addr_reg;
    wdata_next   = wdata_reg;
    port_b_next  = port_b_reg;
    rd_cap_next  = rd_cap_reg;
    a_ack_next   = 1'b0;
    b_ack_next   = 1'b0;
    a_rdata_next = a.rdata;
    b_rdata_next = b.rdata;
`ifndef SRAM_CTRL_FIXED_PRIO_EN
    prio_b_next  = prio_b_reg;
`endif

    case (state_reg)
      IDLE: begin
        if (grant_any) begin
          state_next  = SETUP;
          cnt_next    = SETUP_LD;
          port_b_next = grant_b;
          we_next     = grant_b ? b.we    : a.we;
          addr_next   = grant_b ? b.addr  : a.addr;
          wdata_next  = grant_b ? b.wdata : a.wdata;
`ifndef SRAM_CTRL_FIXED_PRIO_EN
          prio_b_next = !grant_b;
`endif
        end
      end

      SETUP: begin
        if (cnt_reg == 4'd0) begin
          state_next = PULSE;
          cnt_next   = PULSE_LD;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      PULSE: begin
        if (cnt_reg == 4'd0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LD;
          // Capture on the edge closing the strobe, while oe_n is still low.
          if (!we_reg) rd_cap_next = sram_io;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      HOLD: begin
        if (cnt_reg == 4'd0) begin
          state_next = IDLE;
          cnt_next   = 4'd0;
          if (port_b_reg) begin
            b_ack_next = 1'b1;
            if (!we_reg) b_rdata_next = rd_cap_reg;
          end else begin
            a_ack_next = 1'b1;
            if (!we_reg) a_rdata_next = rd_cap_reg;
          end
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  // Pins are derived from the next state and next context so that they are
  // registered and change on the same edge as the FSM, with no path from req.
  always_comb begin
    cs_act       = (state_next != IDLE);
    cs1_n_next   = !cs_act;
    cs2_next     = cs_act;
    we_n_next    = !((state_next == PULSE) && we_next);
    oe_n_next    = !(((state_next == SETUP) || (state_next == PULSE)) && !we_next);
    io_oe_next   = cs_act && we_next;
    io_data_next = wdata_next;
    sram_a_next  = cs_act ? addr_next : sram_a;
  end

endmodule

// File: tb/tb_sram_ctrl_arb.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl_arb
// Directed bench for sram_ctrl_arb: a table of single-port accesses against a
// behavioural SRAM, then hand-written sequences for arbitration, req held past
// ack, reset abort, and a second instance with long timing.
// ---------------------------------------------------------------------------
module tb_sram_ctrl_arb;

  localparam int S1 = 1, P1 = 2, H1 = 1;
  localparam int S2 = 3, P2 = 5, H2 = 2;
  localparam logic [7:0] ZZ = 8'bzzzz_zzzz;
`ifdef SRAM_CTRL_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (default timing) ----------------
  sram_ctrl_arb_if #(.ADDR_W(13), .DATA_W(8)) a_if ();
  sram_ctrl_arb_if #(.ADDR_W(13), .DATA_W(8)) b_if ();
  logic        sram_cs1_n, sram_cs2, sram_we_n, sram_oe_n;
  logic [12:0] sram_a;
  wire  [7:0]  sram_io;

  sram_ctrl_arb dut (
    .clk(clk), .rst_n(rst_n), .a(a_if.slave), .b(b_if.slave),
    .sram_cs1_n(sram_cs1_n), .sram_cs2(sram_cs2), .sram_we_n(sram_we_n),
    .sram_oe_n(sram_oe_n), .sram_a(sram_a), .sram_io(sram_io)
  );

  logic [7:0] mem [0:8191];
  initial for (int i = 0; i < 8192; i++) mem[i] = 8'(i) ^ 8'h5A;
  assign sram_io = (!sram_cs1_n && sram_cs2 && !sram_oe_n && sram_we_n) ? mem[sram_a] : ZZ;
  always @(posedge sram_we_n) if (rst_n && !sram_cs1_n && sram_cs2) mem[sram_a] <= sram_io;

  // ---------------- DUT 2 (long timing) ----------------
  sram_ctrl_arb_if #(.ADDR_W(13), .DATA_W(8)) a2_if ();
  sram_ctrl_arb_if #(.ADDR_W(13), .DATA_W(8)) b2_if ();
  logic        cs1_n2, cs2_2, we_n2, oe_n2;
  logic [12:0] sram_a2;
  wire  [7:0]  io2;

  sram_ctrl_arb #(.SETUP_CYC(S2), .PULSE_CYC(P2), .HOLD_CYC(H2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a2_if.slave), .b(b2_if.slave),
    .sram_cs1_n(cs1_n2), .sram_cs2(cs2_2), .sram_we_n(we_n2),
    .sram_oe_n(oe_n2), .sram_a(sram_a2), .sram_io(io2)
  );
  assign io2 = (!cs1_n2 && cs2_2 && !oe_n2) ? (sram_a2[7:0] ^ 8'h3C) : ZZ;

  // ---------------- Pin monitors (cumulative counters) ----------------
  int cs_cnt = 0, we_cnt = 0, oe_cnt = 0, strobe_bad = 0, drv_bad = 0, addr_bad = 0;
  int oe2_cnt = 0, we2_cnt = 0, a2_bad = 0;
  bit          trk_en = 1'b0;
  logic        trk_we = 1'b0;
  logic [12:0] trk_addr = '0;
  logic [7:0]  trk_wdata = '0;

  always @(negedge clk) begin
    if (!sram_cs1_n) cs_cnt++;
    if (!sram_we_n) we_cnt++;
    if (!sram_oe_n) oe_cnt++;
    if (!sram_we_n && (!sram_oe_n || sram_cs1_n || !sram_cs2)) strobe_bad++;
    if (trk_en && !sram_cs1_n) begin
      if (sram_a !== trk_addr) addr_bad++;
      if (trk_we && sram_io !== trk_wdata) drv_bad++;
      if (!trk_we && sram_oe_n && sram_io !== ZZ) drv_bad++;
      if (!trk_we && !sram_oe_n && sram_io !== mem[trk_addr]) drv_bad++;
    end
    if (!oe_n2) oe2_cnt++;
    if (!we_n2) we2_cnt++;
    if (!cs1_n2 && sram_a2 !== 13'h1FFF) a2_bad++;
  end

  // ---------------- Checking helpers ----------------
  int n_chk = 0, n_fail = 0;
  logic [7:0] last_a_rd = 8'h00, last_b_rd = 8'h00;
  bit rr_prio_b = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp_v, exp_v);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single access on DUT 1; starts and ends at a negedge.
  task automatic do_txn(input bit port_b, input logic we, input logic [12:0] addr,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
    int s_cs, s_we, s_oe, s_sb, s_db, s_ab, lat;
    bit got;
    trk_en = 1'b1; trk_we = we; trk_addr = addr; trk_wdata = wd;
    s_cs = cs_cnt; s_we = we_cnt; s_oe = oe_cnt; s_sb = strobe_bad; s_db = drv_bad; s_ab = addr_bad;
    if (!port_b) begin
      a_if.we = we; a_if.addr = addr; a_if.wdata = wd; a_if.req = 1'b1;
    end else begin
      b_if.we = we; b_if.addr = addr; b_if.wdata = wd; b_if.req = 1'b1;
    end
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      cycle();
      lat++;
      got = port_b ? b_if.ack : a_if.ack;
    end
    if (!port_b) a_if.req = 1'b0; else b_if.req = 1'b0;
    chk("ack_latency", lat, S1 + P1 + H1 + 1);
    chk("wrong_port_ack", int'(port_b ? a_if.ack : b_if.ack), 0);
    if (!we) begin
      chk("rdata", int'(port_b ? b_if.rdata : a_if.rdata), int'(exp_rd));
      if (port_b) last_b_rd = exp_rd; else last_a_rd = exp_rd;
    end
    chk("other_rdata_held", int'(port_b ? a_if.rdata : b_if.rdata), int'(port_b ? last_a_rd : last_b_rd));
    cycle();
    chk("ack_one_cycle", int'(port_b ? b_if.ack : a_if.ack), 0);
    chk("cs_cycles", cs_cnt - s_cs, S1 + P1 + H1);
    chk("we_low_cycles", we_cnt - s_we, we ? P1 : 0);
    chk("oe_low_cycles", oe_cnt - s_oe, we ? 0 : S1 + P1);
    chk("strobe_overlap", strobe_bad - s_sb, 0);
    chk("io_drive", drv_bad - s_db, 0);
    chk("addr_pins", addr_bad - s_ab, 0);
    if (!FIXED) rr_prio_b = !port_b;
    trk_en = 1'b0;
    $display("txn port=%s we=%0d addr=%h wdata=%h lat=%0d rdA=%h rdB=%h",
             port_b ? "B" : "A", we, addr, wd, lat, a_if.rdata, b_if.rdata);
  endtask

  // Wait (bounded) for an ack on DUT 1; returns 0=A, 1=B, -1=timeout/both.
  task automatic wait_ack(output int who);
    int n;
    n = 0; who = -1;
    while (n < 40) begin
      cycle();
      n++;
      if (a_if.ack || b_if.ack) begin
        who = (a_if.ack && b_if.ack) ? -1 : (a_if.ack ? 0 : 1);
        break;
      end
    end
  endtask

  typedef struct {
    bit          port_b;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int who, exp_who, s_cs, acks, lat;
    bit got;

    vecs[0] = '{1'b0, 1'b1, 13'h0005, 8'hA5, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 13'h0005, 8'h00, 8'hA5};
    vecs[2] = '{1'b1, 1'b1, 13'h1FFF, 8'h3C, 8'h00};
    vecs[3] = '{1'b0, 1'b0, 13'h1FFF, 8'h00, 8'h3C};
    vecs[4] = '{1'b0, 1'b1, 13'h0000, 8'hFF, 8'h00};
    vecs[5] = '{1'b1, 1'b0, 13'h0000, 8'h00, 8'hFF};
    vecs[6] = '{1'b1, 1'b0, 13'h0123, 8'h00, 8'h79};  // untouched: 0x23 ^ 0x5A

    a_if.req = 0; a_if.we = 0; a_if.addr = '0; a_if.wdata = '0;
    b_if.req = 0; b_if.we = 0; b_if.addr = '0; b_if.wdata = '0;
    a2_if.req = 0; a2_if.we = 0; a2_if.addr = '0; a2_if.wdata = '0;
    b2_if.req = 0; b2_if.we = 0; b2_if.addr = '0; b2_if.wdata = '0;

    // ---- reset state ----
    @(negedge clk); @(negedge clk);
    chk("rst_cs1_n", int'(sram_cs1_n), 1);
    chk("rst_cs2", int'(sram_cs2), 0);
    chk("rst_we_n", int'(sram_we_n), 1);
    chk("rst_oe_n", int'(sram_oe_n), 1);
    chk("rst_addr", int'(sram_a), 0);
    chk("rst_io_z", int'(sram_io === ZZ), 1);
    chk("rst_acks", int'({a_if.ack, b_if.ack}), 0);
    chk("rst_rdata", int'({a_if.rdata, b_if.rdata}), 0);
    $display("reset checked");
    rst_n = 1'b1;
    cycle();

    // ---- table of single-port accesses ----
    for (int i = 0; i < 7; i++)
      do_txn(vecs[i].port_b, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);

    // ---- both requests held continuously: grants alternate ----
    a_if.we = 1; a_if.addr = 13'h0010; a_if.wdata = 8'h11;
    b_if.we = 1; b_if.addr = 13'h0020; b_if.wdata = 8'h22;
    a_if.req = 1; b_if.req = 1;
    exp_who = (FIXED || !rr_prio_b) ? 0 : 1;
    for (int g = 0; g < 4; g++) begin
      wait_ack(who);
      if (g == 3) begin a_if.req = 0; b_if.req = 0; end
      chk("grant_order", who, exp_who);
      $display("continuous grant %0d -> %s", g, who == 0 ? "A" : (who == 1 ? "B" : "?"));
      if (!FIXED) rr_prio_b = (who == 0);
      // The just-acked port is ineligible, so the other one is granted next.
      exp_who = (who == 0) ? 1 : 0;
    end
    cycle();
    chk("no_grant_after_drop", int'(sram_cs1_n), 1);

    // ---- fresh simultaneous requests: tie-break rule ----
    for (int r = 0; r < 2; r++) begin
      a_if.addr = 13'h0040; b_if.addr = 13'h0050;
      a_if.req = 1; b_if.req = 1;
      exp_who = FIXED ? 0 : (rr_prio_b ? 1 : 0);
      wait_ack(who);
      a_if.req = 0; b_if.req = 0;
      chk("tie_winner", who, exp_who);
      $display("tie %0d -> %s", r, who == 0 ? "A" : (who == 1 ? "B" : "?"));
      if (!FIXED) rr_prio_b = (who == 0);
      cycle();
    end

    // ---- req held one cycle past ack: no second access ----
    a_if.we = 1; a_if.addr = 13'h0030; a_if.wdata = 8'h77; a_if.req = 1;
    wait_ack(who);
    chk("hold_past_ack_first", who, 0);
    if (!FIXED) rr_prio_b = 1'b1;
    s_cs = cs_cnt;
    cycle();
    a_if.req = 0;
    chk("hold_past_ack_cs_gap", int'(sram_cs1_n), 1);
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      if (a_if.ack) acks++;
    end
    chk("hold_past_ack_no_regrant", cs_cnt - s_cs, 0);
    chk("hold_past_ack_no_ack", acks, 0);
    $display("req held past ack: extra cs cycles=%0d", cs_cnt - s_cs);

    // ---- reset during PULSE of a write ----
    a_if.we = 1; a_if.addr = 13'h0100; a_if.wdata = 8'h99; a_if.req = 1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = !sram_we_n;
    end
    chk("abort_reached_pulse", int'(got), 1);
    rst_n = 1'b0;
    #1;
    chk("abort_we_n", int'(sram_we_n), 1);
    chk("abort_cs1_n", int'(sram_cs1_n), 1);
    chk("abort_oe_n", int'(sram_oe_n), 1);
    chk("abort_io_z", int'(sram_io === ZZ), 1);
    chk("abort_no_ack", int'(a_if.ack), 0);
    a_if.req = 0;
    rr_prio_b = 1'b0; last_a_rd = 8'h00; last_b_rd = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (a_if.ack || b_if.ack) acks++;
    end
    chk("abort_no_late_ack", acks, 0);
    chk("abort_rdata_cleared", int'(a_if.rdata), 0);
    $display("reset abort checked");
    do_txn(1'b0, 1'b0, 13'h0005, 8'h00, 8'hA5);

    // ---- DUT 2: long timing read at top address ----
    begin
      int s_oe2, s_we2, s_a2;
      s_oe2 = oe2_cnt; s_we2 = we2_cnt; s_a2 = a2_bad;
      a2_if.we = 0; a2_if.addr = 13'h1FFF; a2_if.req = 1;
      lat = 0; got = 1'b0;
      while (!got && lat < 60) begin
        cycle();
        lat++;
        got = a2_if.ack;
      end
      a2_if.req = 0;
      chk("long_latency", lat, S2 + P2 + H2 + 1);
      chk("long_rdata", int'(a2_if.rdata), 8'hC3);
      cycle();
      chk("long_ack_one_cycle", int'(a2_if.ack), 0);
      chk("long_oe_low", oe2_cnt - s_oe2, S2 + P2);
      chk("long_we_low", we2_cnt - s_we2, 0);
      chk("long_addr", a2_bad - s_a2, 0);
      $display("long txn addr=1fff lat=%0d rdata=%h", lat, a2_if.rdata);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
